// File: rtl/gate_op_pkg.sv
// Shared constants for the gate operation arbiter: opcodes, FSM encodings,
// and the registered result record.
package gate_op_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  typedef struct packed {
    logic data;
    logic err;
  } gate_res_t;

endpackage

// File: rtl/basic_gates.sv
// Seven two-input logic primitives evaluated in parallel on one bit pair.
module basic_gates (
  input  logic a,
  input  logic b,
  output logic y_and,
  output logic y_or,
  output logic y_not,
  output logic y_xor,
  output logic y_nand,
  output logic y_nor,
  output logic y_xnor
);

  assign y_and  = a & b;
  assign y_or   = a | b;
  assign y_not  = ~a;
  assign y_xor  = a ^ b;
  assign y_nand = ~(a & b);
  assign y_nor  = ~(a | b);
  assign y_xnor = ~(a ^ b);

endmodule

// File: rtl/gate_op_arbiter_rr.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]    grant_idx
);

  logic found;
  int   idx;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    idx          = 0;
    // off runs 1..NUM_REQ so ptr itself is visited last
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (en && !found && req[idx]) begin
        found             = 1'b1;
        grant_onehot[idx] = 1'b1;
        grant_idx         = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin sharing of one basic_gates datapath among NUM_REQ requesters,
// with a single registered valid/ready response slot.
module gate_op_arbiter
  import gate_op_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_a,
  input  logic [NUM_REQ-1:0]   req_b,
  input  logic [3*NUM_REQ-1:0] req_op,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_data,
  output logic                 rsp_err
);

  logic [1:0]         state, state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               slot_free, accept;
  logic               sel_a, sel_b;
  logic [2:0]         sel_op;
  logic               y_and, y_or, y_not, y_xor, y_nand, y_nor, y_xnor;
  gate_res_t          res;

  assign rsp_valid = (state != ST_IDLE);
  assign slot_free = !rsp_valid | rsp_ready;

  // Reset gating keeps req_ready low combinationally while rst_n is asserted
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req          (req_valid),
    .en           (slot_free & rst_n),
    .ptr          (rr_ptr),
    .grant_onehot (grant),
    .grant_idx    (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);

  assign sel_a  = req_a[grant_idx];
  assign sel_b  = req_b[grant_idx];
  assign sel_op = req_op[3*int'(grant_idx) +: 3];

  basic_gates u_gates (
    .a      (sel_a),
    .b      (sel_b),
    .y_and  (y_and),
    .y_or   (y_or),
    .y_not  (y_not),
    .y_xor  (y_xor),
    .y_nand (y_nand),
    .y_nor  (y_nor),
    .y_xnor (y_xnor)
  );

  always_comb begin
    res = '{data: 1'b0, err: 1'b0};
    case (sel_op)
      OP_AND:  res.data = y_and;
      OP_OR:   res.data = y_or;
      OP_NOT:  res.data = y_not;
      OP_XOR:  res.data = y_xor;
      OP_NAND: res.data = y_nand;
      OP_NOR:  res.data = y_nor;
      OP_XNOR: res.data = y_xnor;
      default: res.err  = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_FULL;
      ST_FULL:  if (rsp_ready) state_nxt = accept ? ST_FULL : ST_IDLE;
                else           state_nxt = ST_STALL;
      ST_STALL: if (rsp_ready) state_nxt = accept ? ST_FULL : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= ID_W'(NUM_REQ-1);
      rsp_id   <= '0;
      rsp_data <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rr_ptr   <= grant_idx;
        rsp_id   <= grant_idx;
        rsp_data <= res.data;
        rsp_err  <= res.err;
      end
    end
  end

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Directed vector bench for gate_op_arbiter: table of per-cycle stimulus with
// expected grant and response, plus stall/reset/withdraw sequences.
module tb_gate_op_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_a, req_b, req_ready;
  logic [11:0] req_op;
  logic        rsp_valid, rsp_ready, rsp_data, rsp_err;
  logic [1:0]  rsp_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [11:0] op;
    logic        rdy;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [1:0]  exp_id;
    logic        exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  gate_op_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Entered at posedge+1: drive, check req_ready mid-cycle, check response after edge
  task automatic step(input vec_t v, input string tag);
    req_valid = v.valid;
    req_a     = v.a;
    req_b     = v.b;
    req_op    = v.op;
    rsp_ready = v.rdy;
    #3;
    chk({tag, " req_ready"}, 32'(req_ready), 32'(v.exp_ready));
    @(posedge clk);
    #1;
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(v.exp_valid));
    chk({tag, " rsp_id"},    32'(rsp_id),    32'(v.exp_id));
    chk({tag, " rsp_data"},  32'(rsp_data),  32'(v.exp_data));
    chk({tag, " rsp_err"},   32'(rsp_err),   32'(v.exp_err));
  endtask

  initial begin
    logic [3:0] tt [8];
    logic [3:0] row;
    logic       ab_a, ab_b;
    // truth tables indexed by {a,b}
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0011; tt[3] = 4'b0110;
    tt[4] = 4'b0111; tt[5] = 4'b0001; tt[6] = 4'b1001; tt[7] = 4'b0000;

    // 1: lone requester 2, XOR 1^0; rr_ptr starts at 3
    vecs.push_back('{4'b0100, 4'b0100, 4'b0000, 12'h0C0, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0});
    // 2: all valid, ops {3:ILL,2:NAND,1:NOT,0:OR}, a=0101 b=0011; from ptr=2 -> 3,0,1,2,3
    vecs.push_back('{4'b1111, 4'b0101, 4'b0011, 12'hF11, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b1});
    vecs.push_back('{4'b1111, 4'b0101, 4'b0011, 12'hF11, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0});
    vecs.push_back('{4'b1111, 4'b0101, 4'b0011, 12'hF11, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0});
    vecs.push_back('{4'b1111, 4'b0101, 4'b0011, 12'hF11, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0});
    vecs.push_back('{4'b1111, 4'b0101, 4'b0011, 12'hF11, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b1});
    // 4: opcode x operand sweep on requester 0
    for (int op = 0; op < 8; op++) begin
      for (int ab = 0; ab < 4; ab++) begin
        row  = tt[op];
        ab_a = ab[1];
        ab_b = ab[0];
        vecs.push_back('{4'b0001, {3'b000, ab_a}, {3'b000, ab_b}, 12'(op), 1'b1,
                         4'b0001, 1'b1, 2'd0, row[ab], (op == 7)});
      end
    end
    // drain: no accept, rsp_valid drops, last result registers hold
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 12'h000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1});

    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(req_ready), 32'h0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset rsp_id",    32'(rsp_id),    32'h0);
    chk("reset rsp_data",  32'(rsp_data),  32'h0);
    chk("reset rsp_err",   32'(rsp_err),   32'h0);
    rst_n     = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

    // 3: stall with ptr=0 -> grant 1 (XOR 1^0), hold 3 cycles, then grant 2
    step('{4'b1111, 4'b0010, 4'b0000, 12'h6DB, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0}, "stall_load");
    for (int k = 0; k < 3; k++)
      step('{4'b1111, 4'b0010, 4'b0000, 12'h6DB, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 1'b0},
           $sformatf("stall_hold%0d", k));
    step('{4'b1111, 4'b0010, 4'b0000, 12'h6DB, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0}, "stall_release");

    // 5: take requester 3 into STALL, then reset for one cycle
    step('{4'b1000, 4'b0000, 4'b0000, 12'h6DB, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b0}, "rst_pre_load");
    step('{4'b1000, 4'b0000, 4'b0000, 12'h6DB, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b0, 1'b0}, "rst_pre_stall");
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    #3;
    chk("midrst req_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("midrst rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst rsp_id",    32'(rsp_id),    32'h0);
    rst_n = 1'b1;
    step('{4'b1111, 4'b0000, 4'b0000, 12'h6DB, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0}, "post_rst_grant");

    // 6: set ptr=2, grant 3 while 1 waits, then 1 withdraws
    step('{4'b0100, 4'b0000, 4'b0000, 12'h6DB, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0}, "wd_setup");
    step('{4'b1010, 4'b0000, 4'b0000, 12'h6DB, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b0}, "wd_grant3");
    for (int k = 0; k < 3; k++)
      step('{4'b0000, 4'b0000, 4'b0000, 12'h6DB, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0},
           $sformatf("wd_quiet%0d", k));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
